// File: rtl/clk_div_seq_pkg.sv
// Shared types and reset defaults for the clk_div_seq programmable clock divider.
package clk_div_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_DIV   = 11;
  localparam int unsigned DEF_HIGH  = 6;
  localparam int unsigned DEF_BURST = 0;

endpackage

// File: rtl/clk_div_core.sv
// Phase counter plus registered clk_out / rise_pls decode for one divide setting.
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] high,
  output logic             wrap,
  output logic             clk_out,
  output logic             rise_pls
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_nxt;
  logic [CNT_W-1:0] thr;

  // Outputs are decoded from next phase so the flops line up with the phase they describe.
  // Config only changes when phase_nxt is 0, where the decode is 0 for any legal config.
  always_comb begin
    thr       = div - high + ONE;
    wrap      = run && (phase == div);
    phase_nxt = (!run || wrap) ? '0 : phase + ONE;
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      clk_out  <= 1'b0;
      rise_pls <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      clk_out  <= run && (phase_nxt >= thr);
      rise_pls <= run && (phase_nxt == thr);
    end
  end

endmodule

// File: rtl/clk_div_seq.sv
// Clock divider sequencer: config handshake, pending config, burst/stop control, done.
module clk_div_seq
  import clk_div_seq_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 16
) (
  input  logic               clk_50M,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               rise_pls,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   div_a, high_a, div_pd, high_pd;
  logic [BURST_W-1:0] burst_a, burst_pd, per_cnt;
  logic               pend, stop_flg;
  logic               wrap, xfer, cfg_good, burst_end, run_enter, run_exit;

  function automatic logic cfg_ok(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] h);
    return (d != '0) && (h != '0) && (h <= d);
  endfunction

  assign cfg_ready = (state == IDLE) || !pend;

  always_comb begin
    xfer      = cfg_valid && cfg_ready;
    cfg_good  = cfg_ok(cfg_div, cfg_high);
    burst_end = (burst_a != '0) && ((per_cnt + ONE_B) >= burst_a);
    run_enter = (state == IDLE) && start && !stop;
    // A stop seen on the wrap cycle itself ends the run there; the period is already complete.
    run_exit  = wrap && (stop_flg || stop || burst_end);
    state_nxt = state;
    case (state)
      IDLE:    if (run_enter) state_nxt = RUN;
      RUN:     if (run_exit)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      pend     <= 1'b0;
      stop_flg <= 1'b0;
      per_cnt  <= '0;
      div_a    <= CNT_W'(DEF_DIV);
      high_a   <= CNT_W'(DEF_HIGH);
      burst_a  <= BURST_W'(DEF_BURST);
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == RUN);
      done     <= run_exit;
      cfg_err  <= xfer && !cfg_good;
      stop_flg <= (state == RUN) && !run_exit && (stop_flg || stop);

      if (run_enter)
        per_cnt <= '0;
      else if (wrap)
        per_cnt <= per_cnt + ONE_B;

      // A config that landed in pending on the exit wrap is applied in the first IDLE cycle.
      if (state == IDLE) begin
        if (xfer && cfg_good) begin
          div_a   <= cfg_div;
          high_a  <= cfg_high;
          burst_a <= cfg_burst;
        end else if (pend) begin
          div_a   <= div_pd;
          high_a  <= high_pd;
          burst_a <= burst_pd;
        end
        pend <= 1'b0;
      end else begin
        if (wrap && pend) begin
          div_a   <= div_pd;
          high_a  <= high_pd;
          burst_a <= burst_pd;
        end
        pend <= (pend && !wrap) || (xfer && cfg_good);
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if ((state == RUN) && xfer && cfg_good) begin
      div_pd   <= cfg_div;
      high_pd  <= cfg_high;
      burst_pd <= cfg_burst;
    end
  end

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .run      (state == RUN),
    .div      (div_a),
    .high     (high_a),
    .wrap     (wrap),
    .clk_out  (clk_out),
    .rise_pls (rise_pls)
  );

endmodule

// File: tb/tb_clk_div_seq.sv
// Directed bench for clk_div_seq: default divide, config handshake, stop, burst, reject, reset.
module tb_clk_div_seq;

  logic        clk_50M;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_div;
  logic [7:0]  cfg_high;
  logic [15:0] cfg_burst;
  logic        start;
  logic        stop;
  logic        clk_out;
  logic        rise_pls;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_chk  = 0;
  int n_pass = 0;

  clk_div_seq #(
    .CNT_W   (8),
    .BURST_W (16)
  ) dut (
    .clk_50M   (clk_50M),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .clk_out   (clk_out),
    .rise_pls  (rise_pls),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One RUN cycle per step: high phases are hi_start..period-1, rise at hi_start.
  task automatic run_chk(input int period, input int hi_start, input int first_ph,
                         input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      int ph;
      ph = (first_ph + k) % period;
      chk($sformatf("clk_out p%0d/%0d", ph, period), clk_out, ph >= hi_start);
      chk($sformatf("rise p%0d/%0d", ph, period), rise_pls, ph == hi_start);
      chk($sformatf("busy p%0d", ph), busy, 1'b1);
      chk($sformatf("cfg_ready p%0d", ph), cfg_ready, rdy);
      chk($sformatf("done p%0d", ph), done, 1'b0);
      chk($sformatf("cfg_err p%0d", ph), cfg_err, 1'b0);
      tick();
    end
  endtask

  task automatic offer(input logic [7:0] d, input logic [7:0] h, input logic [15:0] b);
    cfg_div   = d;
    cfg_high  = h;
    cfg_burst = b;
    cfg_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0; cfg_burst = '0;
    start = 1'b0; stop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst clk_out", clk_out, 1'b0);
    chk("rst rise", rise_pls, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst cfg_err", cfg_err, 1'b0);
    chk("rst cfg_ready", cfg_ready, 1'b1);

    // Default continuous divide-by-12; a start during RUN must not disturb the phase.
    start = 1'b1; tick();
    run_chk(12, 6, 0, 3, 1'b1);
    start = 1'b0;
    run_chk(12, 6, 3, 21, 1'b1);

    // Reconfigure in RUN: old period finishes, then 8-cycle period high in 4..7.
    offer(8'd7, 8'd4, 16'd0);
    chk("offer rdy", cfg_ready, 1'b1);
    run_chk(12, 6, 0, 1, 1'b1);
    cfg_valid = 1'b0;
    run_chk(12, 6, 1, 11, 1'b0);
    run_chk(8, 4, 0, 8, 1'b1);

    // Back to 12, then stop at phase 2: period runs out through 11.
    offer(8'd11, 8'd6, 16'd0);
    run_chk(8, 4, 0, 1, 1'b1);
    cfg_valid = 1'b0;
    run_chk(8, 4, 1, 7, 1'b0);
    run_chk(12, 6, 0, 2, 1'b1);
    stop = 1'b1;
    run_chk(12, 6, 2, 1, 1'b1);
    stop = 1'b0;
    run_chk(12, 6, 3, 9, 1'b1);
    chk("stop exit busy", busy, 1'b0);
    chk("stop exit clk_out", clk_out, 1'b0);
    chk("stop exit done", done, 1'b1);
    tick();
    chk("stop done once", done, 1'b0);
    chk("stop idle clk_out", clk_out, 1'b0);

    // Burst of 4 x 4 cycles; start+stop together and stop alone in IDLE are no-ops.
    offer(8'd3, 8'd1, 16'd4);
    tick();
    cfg_valid = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    chk("start+stop idle busy", busy, 1'b0);
    start = 1'b0;
    tick();
    chk("stop idle busy", busy, 1'b0);
    chk("stop idle done", done, 1'b0);
    stop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    run_chk(4, 3, 0, 16, 1'b1);
    chk("burst end busy", busy, 1'b0);
    chk("burst end done", done, 1'b1);
    chk("burst end clk_out", clk_out, 1'b0);
    tick();
    chk("burst done once", done, 1'b0);

    // Rejected configs: high > div, then div = 0.
    offer(8'd4, 8'd5, 16'd0);
    tick();
    cfg_valid = 1'b0;
    chk("rej1 cfg_err", cfg_err, 1'b1);
    tick();
    chk("rej1 cfg_err clr", cfg_err, 1'b0);
    offer(8'd0, 8'd1, 16'd0);
    tick();
    cfg_valid = 1'b0;
    chk("rej2 cfg_err", cfg_err, 1'b1);
    tick();
    chk("rej2 cfg_err clr", cfg_err, 1'b0);

    // Active config still div 3/high 1/burst 4; stop in last period coincides with burst end.
    start = 1'b1; tick(); start = 1'b0;
    run_chk(4, 3, 0, 13, 1'b1);
    stop = 1'b1;
    run_chk(4, 3, 1, 1, 1'b1);
    stop = 1'b0;
    run_chk(4, 3, 2, 2, 1'b1);
    chk("coinc done", done, 1'b1);
    chk("coinc busy", busy, 1'b0);
    tick();
    chk("coinc done once a", done, 1'b0);
    tick();
    chk("coinc done once b", done, 1'b0);

    // Reset in the high phase drops clk_out before the next clock edge.
    start = 1'b1; tick(); start = 1'b0;
    run_chk(4, 3, 0, 3, 1'b1);
    chk("pre-rst clk_out", clk_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async rst clk_out", clk_out, 1'b0);
    chk("async rst busy", busy, 1'b0);
    chk("async rst done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("post-rst done", done, 1'b0);
    chk("post-rst busy", busy, 1'b0);
    chk("post-rst cfg_ready", cfg_ready, 1'b1);
    chk("post-rst clk_out", clk_out, 1'b0);
    tick();
    chk("post-rst done b", done, 1'b0);

    // Defaults restored: continuous divide-by-12 again.
    start = 1'b1; tick(); start = 1'b0;
    run_chk(12, 6, 0, 12, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_div_seq.md
CLK_DIV_SEQ -- requirements
Module: clk_div_seq

Interface
REQ-001 Parameters SHALL be:
- CNT_W, default 8, width of divide/high fields.
- BURST_W, default 16, width of the burst period count.

REQ-002 Ports SHALL be:
- clk_50M  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept.
- cfg_div  in  CNT_W  period minus one, in cycles.
- cfg_high  in  CNT_W  high-phase length, in cycles.
- cfg_burst  in  BURST_W  periods to run; 0 means continuous.
- start  in  1  begin generation.
- stop  in  1  request stop.
- clk_out  out  1  divided clock, registered.
- rise_pls  out  1  one-cycle pulse on each clk_out rising edge.
- busy  out  1  generation active.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse when a config is rejected.

Function
REQ-003 Config handshake: transfer SHALL occur when cfg_valid and cfg_ready are both high on a clk_50M edge.
REQ-004 A config SHALL be rejected when cfg_div < 1, cfg_high = 0 or cfg_high > cfg_div; rejection pulses cfg_err in the next cycle and leaves the active and pending configs unchanged.
REQ-005 The state machine SHALL have states IDLE and RUN.
REQ-006 In IDLE: cfg_ready = 1; an accepted config SHALL load the active registers directly.
REQ-007 In RUN: an accepted config SHALL go to a pending register; cfg_ready = 0 while a config is pending.
REQ-008 The pending config SHALL become active at the phase wrap from div to 0, and the pending flag SHALL clear in that same cycle.
REQ-009 IDLE to RUN SHALL occur on start = 1 with stop = 0; the first RUN cycle is phase 0.
REQ-010 start with stop in the same IDLE cycle SHALL leave the block in IDLE; start during RUN SHALL be ignored.
REQ-011 In RUN, phase p SHALL count 0..div and wrap to 0.
REQ-012 clk_out SHALL be 1 exactly in cycles with p >= div+1-high, and 0 in IDLE.
REQ-013 rise_pls SHALL be 1 exactly in cycles with p = div+1-high.
REQ-014 Each wrap SHALL increment a completed-period counter, which clears on entry to RUN.
REQ-015 With burst != 0, the wrap completing period number burst SHALL return the block to IDLE.
REQ-016 stop during RUN SHALL set a stop flag; at the next wrap the block SHALL return to IDLE. The current period is never truncated, so clk_out has no glitch.
REQ-017 done SHALL pulse one cycle, in the first IDLE cycle after RUN exits.
REQ-018 If stop and burst completion coincide, done SHALL pulse exactly once.
REQ-019 stop in IDLE SHALL be ignored and SHALL not be remembered.
REQ-020 busy SHALL be 1 exactly while in RUN.
REQ-021 Any pending config SHALL be applied on exit to IDLE.
REQ-022 All outputs SHALL be driven from flops with no combinational path from inputs to outputs, except cfg_ready, which is decoded from state and the pending flag.

Reset
REQ-023 On rst: state = IDLE, p = 0, period count = 0, pending and stop flags = 0.
REQ-024 On rst, outputs SHALL be clk_out = 0, rise_pls = 0, done = 0, cfg_err = 0, busy = 0 and cfg_ready = 1 (once rst is released).
REQ-025 The active config SHALL reset to div = 11, high = 6, burst = 0 (continuous divide-by-12, high in phases 6..11).
REQ-026 rst asserted mid-RUN SHALL force clk_out low immediately and SHALL NOT produce done.

Structure
REQ-027 A shared package clk_div_seq_pkg SHALL hold:
- the state enum (IDLE, RUN);
- the reset constants DEF_DIV = 11, DEF_HIGH = 6, DEF_BURST = 0.
REQ-028 The phase counter and the clk_out/rise decode SHALL be one sub-module, clk_div_core, with inputs div, high and run; the sequencer owns the handshake, the pending config, the burst/stop logic and done.

Verification
REQ-029 Reset then start, no config:
- clk_out has period 12, low in phases 0..5 and high in phases 6..11;
- rise_pls occurs every 12 cycles;
- busy = 1.
REQ-030 In IDLE load div = 3, high = 1, burst = 4, then start:
- exactly 4 periods of 4 cycles, each high in phase 3;
- busy falls after the 16th RUN cycle;
- done pulses once.
REQ-031 In RUN (div = 11) offer div = 7, high = 4:
- cfg_ready drops;
- the current 12-cycle period completes, the next period is 8 cycles high in phases 4..7, and cfg_ready returns to 1.
REQ-032 stop asserted at phase 2 of a continuous run:
- the period completes through phase 11, then IDLE with clk_out = 0;
- done pulses once, with no short high pulse.
REQ-033 Offer div = 4, high = 5, and separately div = 0, high = 1:
- each rejected, cfg_err pulses, the active config is unchanged;
- stop plus burst-end on the same wrap gives a single done pulse;
- rst asserted mid-high-phase drives clk_out low asynchronously with no done.
